// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter for the shared SoC memory bus: one buffered request
// per port, one transaction in flight, zero-latency response routing and timeout abort.
module memory_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_error,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_error,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        drop_error
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t           r_state;
  logic             r_pend0, r_pend1;
  logic             r_last;
  logic             r_owner;
  logic             r_drop;
  logic             r_mem_valid;
  logic [CNT_W-1:0] r_cnt;
  req_t             r_buf0, r_buf1, r_mem;

  logic w_busy, w_tmo, w_done, w_done0, w_done1;
  logic w_acc0, w_acc1, w_drop, w_any, w_gnt;
  req_t w_req0, w_req1;

  assign w_req0 = '{instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign w_req1 = '{instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

  assign w_busy  = (r_state == BUSY);
  assign w_tmo   = (TIMEOUT != 0) && w_busy && !mem_ready && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_done  = w_busy && (mem_ready || w_tmo);
  assign w_done0 = w_done && !r_owner;
  assign w_done1 = w_done &&  r_owner;

  // A port that owns the bus may queue its next request only in its completion cycle.
  assign w_acc0 = m0_valid && !r_pend0 && !(w_busy && !r_owner && !w_done);
  assign w_acc1 = m1_valid && !r_pend1 && !(w_busy &&  r_owner && !w_done);
  assign w_drop = (m0_valid && !w_acc0) || (m1_valid && !w_acc1);

  assign w_any = r_pend0 || r_pend1;
  assign w_gnt = (r_pend0 && r_pend1) ? ~r_last : r_pend1;

  assign m0_ready = w_done0;
  assign m1_ready = w_done1;
  assign m0_error = w_done0 && w_tmo;
  assign m1_error = w_done1 && w_tmo;
  assign m0_rdata = (w_done0 && mem_ready) ? mem_rdata : 32'h0;
  assign m1_rdata = (w_done1 && mem_ready) ? mem_rdata : 32'h0;

  assign mem_valid  = r_mem_valid;
  assign mem_instr  = r_mem.instr;
  assign mem_addr   = r_mem.addr;
  assign mem_wdata  = r_mem.wdata;
  assign mem_wstrb  = r_mem.wstrb;
  assign drop_error = r_drop;

  always_ff @(posedge clk) begin
    if (w_acc0) r_buf0 <= w_req0;
    if (w_acc1) r_buf1 <= w_req1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pend0     <= 1'b0;
      r_pend1     <= 1'b0;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_drop      <= 1'b0;
      r_mem_valid <= 1'b0;
      r_cnt       <= '0;
      r_mem       <= '0;
    end else begin
      if (w_drop) r_drop <= 1'b1;
      r_mem_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner     <= w_gnt;
            r_last      <= w_gnt;
            r_mem       <= w_gnt ? r_buf1 : r_buf0;
            r_mem_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= BUSY;
            if (w_gnt) r_pend1 <= 1'b0;
            else       r_pend0 <= 1'b0;
          end
        end
        BUSY: begin
          if (w_done) begin
            r_state <= IDLE;
            r_mem   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
      // Accepted captures come last so a set overrides the grant-time clear.
      if (w_acc0) r_pend0 <= 1'b1;
      if (w_acc1) r_pend1 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level model.
module tb_memory_arbiter;
  localparam int TMO = 8;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_valid = 0, m0_instr = 0, m1_valid = 0, m1_instr = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic        m0_ready, m0_error, m1_ready, m1_error;
  logic        mem_valid, mem_instr, drop_error;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 0;
  logic        mem_ready = 0;

  memory_arbiter #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_error(m0_error),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_error(m1_error),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .drop_error(drop_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Transaction-level model: pending slot per port, one in-flight request, age since issue.
  bit   mbusy;
  int   mowner, mage, mlast;
  bit   mpend[2];
  req_t mbuf[2];
  req_t mcur;
  bit   mdrop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic req_t rq(input logic instr, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s);
    rq = '{instr: instr, addr: a, wdata: d, wstrb: s};
  endfunction

  task automatic model_reset();
    mbusy = 0; mowner = 0; mage = 0; mlast = 1;
    mpend[0] = 0; mpend[1] = 0; mcur = '0; mdrop = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".m0_ready"}, m0_ready, 0);  chk({tag, ".m0_rdata"}, m0_rdata, 0);
    chk({tag, ".m0_error"}, m0_error, 0);  chk({tag, ".m1_ready"}, m1_ready, 0);
    chk({tag, ".m1_rdata"}, m1_rdata, 0);  chk({tag, ".m1_error"}, m1_error, 0);
    chk({tag, ".mem_valid"}, mem_valid, 0); chk({tag, ".mem_instr"}, mem_instr, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);  chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".mem_wstrb"}, mem_wstrb, 0); chk({tag, ".drop_error"}, drop_error, 0);
  endtask

  task automatic do_reset();
    m0_valid = 0; m1_valid = 0; mem_ready = 0;
    @(posedge clk); #2 rst = 1;
    #1 check_all_zero("reset");
    model_reset();
    @(posedge clk); #2 rst = 0;
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance the model.
  task automatic step(input bit v0, input req_t r0, input bit v1, input req_t r1,
                      input bit mr, input logic [31:0] mrd);
    bit   rdy, tmo, acc[2], vv[2];
    req_t rr[2];
    req_t pay;
    int   g;
    @(posedge clk); #1;
    m0_valid = v0; m0_instr = r0.instr; m0_addr = r0.addr; m0_wdata = r0.wdata; m0_wstrb = r0.wstrb;
    m1_valid = v1; m1_instr = r1.instr; m1_addr = r1.addr; m1_wdata = r1.wdata; m1_wstrb = r1.wstrb;
    mem_ready = mr; mem_rdata = mrd;
    @(negedge clk);
    tmo = mbusy && !mr && (mage == TMO - 1);
    rdy = mbusy && (mr || tmo);
    pay = mbusy ? mcur : '0;
    chk("mem_valid", mem_valid, (mbusy && mage == 0));
    chk("mem_instr", mem_instr, pay.instr);
    chk("mem_addr",  mem_addr,  pay.addr);
    chk("mem_wdata", mem_wdata, pay.wdata);
    chk("mem_wstrb", mem_wstrb, pay.wstrb);
    chk("m0_ready", m0_ready, rdy && mowner == 0);
    chk("m1_ready", m1_ready, rdy && mowner == 1);
    chk("m0_error", m0_error, tmo && mowner == 0);
    chk("m1_error", m1_error, tmo && mowner == 1);
    chk("m0_rdata", m0_rdata, (rdy && mr && mowner == 0) ? mrd : 32'h0);
    chk("m1_rdata", m1_rdata, (rdy && mr && mowner == 1) ? mrd : 32'h0);
    chk("drop_error", drop_error, mdrop);
    vv[0] = v0; vv[1] = v1; rr[0] = r0; rr[1] = r1;
    for (int n = 0; n < 2; n++) begin
      acc[n] = vv[n] && !mpend[n] && !(mbusy && mowner == n && !rdy);
      if (vv[n] && !acc[n]) mdrop = 1;
    end
    if (mbusy) begin
      if (rdy) mbusy = 0;
      else mage++;
    end else if (mpend[0] || mpend[1]) begin
      g = (mpend[0] && mpend[1]) ? 1 - mlast : (mpend[1] ? 1 : 0);
      mowner = g; mlast = g; mcur = mbuf[g]; mpend[g] = 0; mbusy = 1; mage = 0;
    end
    for (int n = 0; n < 2; n++)
      if (acc[n]) begin mpend[n] = 1; mbuf[n] = rr[n]; end
  endtask

  task automatic idle(input int n, input logic [31:0] mrd);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, mrd);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Single read, plus a new port-0 request in the completion cycle
    step(1, rq(0, 32'h100, 0, 0), 0, '0, 0, 0);
    chk("sr.c0.mem_valid", mem_valid, 0);
    step(0, '0, 0, '0, 0, 0);
    chk("sr.c1.mem_valid", mem_valid, 0);
    step(0, '0, 0, '0, 0, 0);
    chk("sr.c2.mem_valid", mem_valid, 1);
    chk("sr.c2.mem_addr", mem_addr, 32'h100);
    step(1, rq(0, 32'h104, 0, 0), 0, '0, 1, 32'hDEADBEEF);
    chk("sr.c3.m0_ready", m0_ready, 1);
    chk("sr.c3.m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("sr.c3.m1_ready", m1_ready, 0);
    step(0, '0, 0, '0, 0, 0);
    chk("sr.c4.drop_error", drop_error, 0);
    step(0, '0, 0, '0, 1, 32'h11);
    chk("sr.c5.mem_addr", mem_addr, 32'h104);
    chk("sr.c5.m0_ready", m0_ready, 1);
    idle(1, 0);
    chk("sr.c6.drop_error", drop_error, 0);

    // Collision after reset: port 0 first, then port 1
    do_reset();
    step(1, rq(0, 32'hA0, 0, 0), 1, rq(0, 32'hB0, 0, 0), 0, 0);
    idle(1, 0);
    step(0, '0, 0, '0, 1, 32'h1);
    chk("col1.first_addr", mem_addr, 32'hA0);
    chk("col1.m0_ready", m0_ready, 1);
    idle(1, 0);
    step(0, '0, 0, '0, 1, 32'h2);
    chk("col1.second_addr", mem_addr, 32'hB0);
    chk("col1.m1_ready", m1_ready, 1);
    chk("col1.m0_ready_low", m0_ready, 0);
    idle(1, 0);
    // A lone port-0 transaction leaves port 0 as last grant, so the next collision favours port 1
    step(1, rq(0, 32'hC0, 0, 0), 0, '0, 0, 0);
    idle(1, 0);
    step(0, '0, 0, '0, 1, 32'h3);
    chk("solo.addr", mem_addr, 32'hC0);
    idle(1, 0);
    step(1, rq(0, 32'hA1, 0, 0), 1, rq(0, 32'hB1, 0, 0), 0, 0);
    idle(1, 0);
    step(0, '0, 0, '0, 1, 32'h4);
    chk("col2.first_addr", mem_addr, 32'hB1);
    chk("col2.m1_ready", m1_ready, 1);
    idle(1, 0);
    step(0, '0, 0, '0, 1, 32'h5);
    chk("col2.second_addr", mem_addr, 32'hA1);
    chk("col2.m0_ready", m0_ready, 1);
    idle(1, 0);

    // Write passthrough on port 1
    step(0, '0, 1, rq(0, 32'h2000_0000, 32'h55, 4'h1), 0, 0);
    idle(1, 0);
    step(0, '0, 0, '0, 0, 0);
    chk("wr.mem_valid", mem_valid, 1);
    chk("wr.mem_addr", mem_addr, 32'h2000_0000);
    chk("wr.mem_wdata", mem_wdata, 32'h55);
    chk("wr.mem_wstrb", mem_wstrb, 4'h1);
    chk("wr.mem_instr", mem_instr, 0);
    step(0, '0, 0, '0, 1, 32'h0);
    chk("wr.m1_ready", m1_ready, 1);
    chk("wr.m1_error", m1_error, 0);
    chk("wr.addr_held", mem_addr, 32'h2000_0000);
    idle(1, 0);

    // Timeout: forced completion in the 8th busy cycle, rdata forced to zero
    step(1, rq(1, 32'h300, 0, 0), 0, '0, 0, 32'hFFFF_FFFF);
    idle(1, 32'hFFFF_FFFF);
    step(0, '0, 0, '0, 0, 32'hFFFF_FFFF);
    chk("tmo.issue", mem_valid, 1);
    chk("tmo.instr", mem_instr, 1);
    for (int k = 1; k < TMO - 1; k++) begin
      step(0, '0, 0, '0, 0, 32'hFFFF_FFFF);
      chk("tmo.early_ready", m0_ready, 0);
    end
    step(0, '0, 0, '0, 0, 32'hFFFF_FFFF);
    chk("tmo.m0_ready", m0_ready, 1);
    chk("tmo.m0_error", m0_error, 1);
    chk("tmo.m0_rdata", m0_rdata, 0);
    idle(1, 0);
    chk("tmo.idle_addr", mem_addr, 0);
    chk("tmo.idle_ready", m0_ready, 0);

    // Drop: second pulse while the first is still pending
    step(1, rq(0, 32'h400, 0, 0), 0, '0, 0, 0);
    step(1, rq(0, 32'h404, 0, 0), 0, '0, 0, 0);
    step(0, '0, 0, '0, 0, 0);
    chk("drop.addr", mem_addr, 32'h400);
    chk("drop.flag", drop_error, 1);
    step(0, '0, 0, '0, 1, 32'h77);
    chk("drop.m0_ready", m0_ready, 1);
    idle(3, 0);
    chk("drop.sticky", drop_error, 1);
    chk("drop.no_reissue", mem_valid, 0);

    // Asynchronous reset while busy
    step(0, '0, 1, rq(0, 32'h500, 0, 0), 0, 0);
    idle(1, 0);
    step(0, '0, 0, '0, 0, 0);
    chk("arst.busy", mem_valid, 1);
    #2 rst = 1;
    #1 check_all_zero("arst");
    model_reset();
    @(posedge clk); #2 rst = 0;
    idle(4, 0);
    chk("arst.no_ready", m1_ready, 0);
    step(1, rq(0, 32'h600, 0, 0), 0, '0, 0, 0);
    idle(1, 0);
    step(0, '0, 0, '0, 1, 32'h66);
    chk("arst.next_addr", mem_addr, 32'h600);
    chk("arst.next_ready", m0_ready, 1);
    chk("arst.next_rdata", m0_rdata, 32'h66);
    idle(1, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(3) == 0,
           rq(1'($urandom), $urandom, $urandom, 4'($urandom)),
           $urandom_range(3) == 0,
           rq(1'($urandom), $urandom, $urandom, 4'($urandom)),
           $urandom_range(3) == 0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
